// File: rtl/mem_responder.sv
// mem_responder: single-outstanding request/response memory with a fixed number of wait states.
//
// A request is accepted in IDLE when req_valid && req_ready. The FSM then spends WAIT_CYCLES
// cycles in WAIT and enters RESP, where the response is held until rsp_ready. Writes land in
// the array on the edge that enters RESP, so any later read observes them.
//
// Parameters:
//   WIDTH        data word width
//   ADDR         word address width (depth = 2**ADDR)
//   WAIT_CYCLES  wait states between accept and response, 0..15
//
// Ports:
//   clk          sole clock, rising edge
//   reset        synchronous active-high reset (FSM and outputs only, memory untouched)
//   req_valid    request present
//   req_ready    responder idle and able to accept
//   req_addr     word address
//   req_wr_en    1 = write, 0 = read
//   req_wdata    write data
//   rsp_valid    response available
//   rsp_ready    initiator takes the response
//   rsp_rdata    read data, or the data just written for a write
//   rsp_was_wr   response belongs to a write
//   rd_count     (MEM_RESPONDER_STATS_EN only) saturating count of accepted reads
//   wr_count     (MEM_RESPONDER_STATS_EN only) saturating count of accepted writes
//
// Optional feature macro: MEM_RESPONDER_STATS_EN adds the rd_count / wr_count outputs.

module mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR        = 5,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ADDR-1:0]  req_addr,
  input  logic             req_wr_en,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
`ifdef MEM_RESPONDER_STATS_EN
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count,
`endif
  output logic             rsp_was_wr
);

  localparam int unsigned Depth = 2 ** ADDR;
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [ADDR-1:0]    addr_q;
  logic               wr_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_rdata_q;
  logic               rsp_was_wr_q;

  logic [WIDTH-1:0]   mem_q [Depth];

  logic               accept;
  logic               commit;
  logic [ADDR-1:0]    commit_addr;
  logic               commit_wr;
  logic [WIDTH-1:0]   commit_wdata;
  logic [WIDTH-1:0]   commit_rdata;

  assign accept = req_valid && req_ready_q;

  // The transaction reaching RESP this edge: straight from the request ports when there are
  // no wait states, otherwise from the captured request.
  always_comb begin
    commit       = 1'b0;
    commit_addr  = addr_q;
    commit_wr    = wr_q;
    commit_wdata = wdata_q;
    if (state_q == StIdle) begin
      commit       = accept && (WAIT_CYCLES == 0);
      commit_addr  = req_addr;
      commit_wr    = req_wr_en;
      commit_wdata = req_wdata;
    end else if (state_q == StWait) begin
      commit = (cnt_q == 4'd0);
    end
  end

  // A write returns the data it wrote; a read sees the array before this edge's update,
  // which cannot target it anyway since only one transaction is in flight.
  assign commit_rdata = commit_wr ? commit_wdata : mem_q[commit_addr];

  // Memory has no reset; a reset that coincides with the commit edge aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && commit_wr) begin
      mem_q[commit_addr] <= commit_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_was_wr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q      <= req_addr;
            wr_q        <= req_wr_en;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state_q      <= StResp;
              rsp_valid_q  <= 1'b1;
              rsp_rdata_q  <= commit_rdata;
              rsp_was_wr_q <= commit_wr;
            end else begin
              state_q <= StWait;
              cnt_q   <= WaitLoad;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q      <= StResp;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= commit_rdata;
            rsp_was_wr_q <= commit_wr;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          // req_ready only rises after leaving RESP, so no accept on the handshake edge.
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_was_wr = rsp_was_wr_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else if (accept) begin
      if (req_wr_en) begin
        if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  // Statistics disabled: no counter state exists.
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: one instance with two wait states and one
// with none. Build with MEM_RESPONDER_STATS_EN defined to also exercise the counters.

module tb_mem_responder;

  logic clk;
  logic reset;

  // Instance A: WAIT_CYCLES = 2
  logic        a_req_valid, a_req_ready, a_req_wr_en, a_rsp_valid, a_rsp_ready, a_rsp_was_wr;
  logic [4:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata;
  // Instance B: WAIT_CYCLES = 0
  logic        b_req_valid, b_req_ready, b_req_wr_en, b_rsp_valid, b_rsp_ready, b_rsp_was_wr;
  logic [4:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] a_rd_count, a_wr_count, b_rd_count, b_wr_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_responder #(.WIDTH(32), .ADDR(5), .WAIT_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (a_req_valid),
    .req_ready  (a_req_ready),
    .req_addr   (a_req_addr),
    .req_wr_en  (a_req_wr_en),
    .req_wdata  (a_req_wdata),
    .rsp_valid  (a_rsp_valid),
    .rsp_ready  (a_rsp_ready),
    .rsp_rdata  (a_rsp_rdata),
`ifdef MEM_RESPONDER_STATS_EN
    .rd_count   (a_rd_count),
    .wr_count   (a_wr_count),
`endif
    .rsp_was_wr (a_rsp_was_wr)
  );

  mem_responder #(.WIDTH(32), .ADDR(5), .WAIT_CYCLES(0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (b_req_valid),
    .req_ready  (b_req_ready),
    .req_addr   (b_req_addr),
    .req_wr_en  (b_req_wr_en),
    .req_wdata  (b_req_wdata),
    .rsp_valid  (b_rsp_valid),
    .rsp_ready  (b_rsp_ready),
    .rsp_rdata  (b_rsp_rdata),
`ifdef MEM_RESPONDER_STATS_EN
    .rd_count   (b_rd_count),
    .wr_count   (b_wr_count),
`endif
    .rsp_was_wr (b_rsp_was_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance A (sel=0) or B (sel=1), starting from IDLE.
  // lat = cycles from the accept edge until rsp_valid is seen (0 = never seen).
  task automatic txn(input bit sel, input logic [4:0] a, input bit wr, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic was);
    logic v;
    if (sel) begin
      b_req_valid = 1'b1; b_req_addr = a; b_req_wr_en = wr; b_req_wdata = d;
    end else begin
      a_req_valid = 1'b1; a_req_addr = a; a_req_wr_en = wr; a_req_wdata = d;
    end
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    lat = 0;
    rd  = 'x;
    was = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      v = sel ? b_rsp_valid : a_rsp_valid;
      if (v) begin
        lat = i;
        rd  = sel ? b_rsp_rdata : a_rsp_rdata;
        was = sel ? b_rsp_was_wr : a_rsp_was_wr;
        break;
      end
      step();
    end
    if (sel) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    b_rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (a_req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", a_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (a_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", a_rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (a_rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 0", a_rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (a_rsp_was_wr !== 1'b0) $display("FAIL reset_was_wr: got %b expected 0", a_rsp_was_wr);
    else pass_cnt++;
    total_cnt++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0)
      $display("FAIL reset_b: got ready=%b valid=%b expected 1/0", b_req_ready, b_rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rd; logic was;
    txn(1'b0, 5'd3, 1'b1, 32'hDEADBEEF, lat, rd, was);
    total_cnt++;
    if (lat != 3) $display("FAIL wr_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++;
    if (was !== 1'b1) $display("FAIL wr_was_wr: got %b expected 1", was); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL wr_echo: got %h expected deadbeef", rd);
    else pass_cnt++;
    txn(1'b0, 5'd3, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (lat != 3) $display("FAIL rd_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h expected deadbeef", rd);
    else pass_cnt++;
    total_cnt++;
    if (was !== 1'b0) $display("FAIL rd_was_wr: got %b expected 0", was); else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    int lat; logic [31:0] rd; logic was;
    txn(1'b1, 5'd5, 1'b1, 32'h12345678, lat, rd, was);
    total_cnt++;
    if (lat != 1) $display("FAIL zw_wr_latency: got %0d expected 1", lat); else pass_cnt++;
    txn(1'b1, 5'd5, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (lat != 1) $display("FAIL zw_rd_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h12345678 || was !== 1'b0)
      $display("FAIL zw_rd_data: got %h/%b expected 12345678/0", rd, was);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic was;
    bit ok_valid, ok_data, ok_ready, seen;
    a_req_valid = 1'b1; a_req_addr = 5'd3; a_req_wr_en = 1'b0; a_req_wdata = 32'h0;
    step();
    a_req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (a_rsp_valid) begin seen = 1'b1; break; end
      step();
    end
    total_cnt++;
    if (!seen) $display("FAIL bp_rsp_seen: got 0 expected 1"); else pass_cnt++;
    ok_valid = 1'b1; ok_data = 1'b1; ok_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      // Write requests offered while busy must be dropped.
      a_req_valid = (i % 2 == 0); a_req_wr_en = 1'b1; a_req_wdata = 32'h0;
      step();
      if (a_rsp_valid !== 1'b1) ok_valid = 1'b0;
      if (a_rsp_rdata !== 32'hDEADBEEF) ok_data = 1'b0;
      if (a_req_ready !== 1'b0) ok_ready = 1'b0;
    end
    a_req_valid = 1'b0;
    total_cnt++;
    if (!ok_valid) $display("FAIL bp_valid_stable: got drop expected held 1"); else pass_cnt++;
    total_cnt++;
    if (!ok_data) $display("FAIL bp_data_stable: got %h expected deadbeef", a_rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (!ok_ready) $display("FAIL bp_req_ready: got 1 expected 0 throughout"); else pass_cnt++;
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    total_cnt++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", a_rsp_valid, a_req_ready);
    else pass_cnt++;
    txn(1'b0, 5'd3, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (rd !== 32'hDEADBEEF) $display("FAIL bp_ignored: got %h expected deadbeef", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic was;
    txn(1'b0, 5'd7, 1'b1, 32'h1, lat, rd, was);
    a_req_valid = 1'b1; a_req_addr = 5'd7; a_req_wr_en = 1'b1; a_req_wdata = 32'hCAFEF00D;
    step();
    a_req_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0)
      $display("FAIL rm_idle: got ready=%b valid=%b expected 1/0", a_req_ready, a_rsp_valid);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b0) $display("FAIL rm_no_rsp: got %b expected 0", a_rsp_valid);
    else pass_cnt++;
    txn(1'b0, 5'd7, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL rm_no_write: got %h expected 00000001", rd); else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int lat; logic [31:0] rd; logic was;
    txn(1'b0, 5'd0, 1'b1, 32'hA5A5A5A5, lat, rd, was);
    txn(1'b0, 5'd31, 1'b1, 32'h5A5A5A5A, lat, rd, was);
    txn(1'b0, 5'd0, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (rd !== 32'hA5A5A5A5) $display("FAIL addr0: got %h expected a5a5a5a5", rd);
    else pass_cnt++;
    txn(1'b0, 5'd31, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (rd !== 32'h5A5A5A5A) $display("FAIL addr31: got %h expected 5a5a5a5a", rd);
    else pass_cnt++;
  endtask

`ifdef MEM_RESPONDER_STATS_EN
  task automatic test_stats();
    int lat; logic [31:0] rd; logic was;
    do_reset();
    txn(1'b0, 5'd1, 1'b0, 32'h0, lat, rd, was);
    txn(1'b0, 5'd2, 1'b1, 32'h22, lat, rd, was);
    txn(1'b0, 5'd2, 1'b0, 32'h0, lat, rd, was);
    txn(1'b0, 5'd4, 1'b1, 32'h44, lat, rd, was);
    txn(1'b0, 5'd4, 1'b0, 32'h0, lat, rd, was);
    total_cnt++;
    if (a_rd_count !== 16'd3) $display("FAIL rd_count: got %0d expected 3", a_rd_count);
    else pass_cnt++;
    total_cnt++;
    if (a_wr_count !== 16'd2) $display("FAIL wr_count: got %0d expected 2", a_wr_count);
    else pass_cnt++;
    do_reset();
    total_cnt++;
    if (a_rd_count !== 16'd0 || a_wr_count !== 16'd0)
      $display("FAIL stats_reset: got %0d/%0d expected 0/0", a_rd_count, a_wr_count);
    else pass_cnt++;
  endtask
`endif

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_addr = '0; a_req_wr_en = 1'b0; a_req_wdata = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = '0; b_req_wr_en = 1'b0; b_req_wdata = '0;
    b_rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_zero_wait();
    test_backpressure();
    test_reset_mid();
    test_boundaries();
`ifdef MEM_RESPONDER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR, default 5, word address width; depth = 2**ADDR words.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, wait states between request accept and response.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_addr  input  ADDR  word address.
REQ-009 SHALL have port req_wr_en  input  1  1 = write, 0 = read.
REQ-010 SHALL have port req_wdata  input  WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  WIDTH  read data; for writes, the data just written.
REQ-014 SHALL have port rsp_was_wr  output  1  response belongs to a write.

Function
REQ-015 SHALL accept a request on a clk edge where req_valid and req_ready are both 1, capturing addr, wr_en and wdata.
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 SHALL move IDLE->WAIT on accept when WAIT_CYCLES > 0, and IDLE->RESP directly when WAIT_CYCLES = 0.
REQ-018 SHALL load a wait counter with WAIT_CYCLES-1 on accept, decrement it each WAIT cycle, and move to RESP on the cycle after it reads 0; accept-to-rsp_valid latency = WAIT_CYCLES+1 cycles.
REQ-019 SHALL perform the array write on the WAIT->RESP (or IDLE->RESP) transition edge, so a read issued after a write to the same address returns the new data.
REQ-020 SHALL register rsp_rdata and rsp_was_wr on entry to RESP and hold them stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL return RESP->IDLE on the edge where rsp_ready=1; req_ready rises the following cycle (no same-cycle accept in RESP).
REQ-022 SHALL ignore req_* inputs while not in IDLE; no request is queued.
REQ-023 SHALL leave memory contents unspecified after power-up and SHALL not alter them on reset.
REQ-024 SHALL treat all ADDR-bit addresses as valid; no wrap or error logic.

Reset
REQ-025 SHALL, when reset=1 at a clk edge, enter IDLE, clear the wait counter, and drive req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_was_wr=0 the following cycle.
REQ-026 SHALL abort a request in WAIT on reset with no memory write performed; a write response pending in RESP has already committed.

Configuration
REQ-027 SHALL, with macro MEM_RESPONDER_STATS_EN defined, add outputs rd_count and wr_count (16 bits each), each incremented on a read or write accept, saturating at 16'hFFFF and cleared by reset.
REQ-028 SHALL, without MEM_RESPONDER_STATS_EN, omit the rd_count and wr_count ports and counters entirely; all other behaviour SHALL be unchanged.

Verification
REQ-029 SHALL cover a write then a read (WAIT_CYCLES=2): write addr 3 data 32'hDEADBEEF -> rsp_valid 3 cycles after accept, rsp_was_wr=1; read addr 3 -> rsp_rdata=32'hDEADBEEF, rsp_was_wr=0.
REQ-030 SHALL cover zero wait states (WAIT_CYCLES=0): read accepted at cycle N -> rsp_valid=1 at cycle N+1.
REQ-031 SHALL cover response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout, req_valid pulses ignored.
REQ-032 SHALL cover reset mid-operation: reset during WAIT of a write to addr 7 (prior value 32'h1) -> IDLE next cycle, later read of addr 7 returns 32'h1.
REQ-033 SHALL cover address boundaries: write addr 0 = 32'hA5A5A5A5 and addr 31 = 32'h5A5A5A5A -> reads return each value unchanged.
REQ-034 SHALL cover stats with MEM_RESPONDER_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; reset -> both 0.
